// File: rtl/occupancy_pkg.sv
// Shared display constants and types for the parking-lot occupancy counter.
// Glyphs are active-low, ordered [0:6] = segments a..g.
package occupancy_pkg;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_C     = 7'b0110001;
    localparam logic [0:6] SEG_L     = 7'b1110001;
    localparam logic [0:6] SEG_E     = 7'b0110000;
    localparam logic [0:6] SEG_A     = 7'b0001000;
    localparam logic [0:6] SEG_r     = 7'b1111010;
    localparam logic [0:6] SEG_F     = 7'b0111000;
    localparam logic [0:6] SEG_U     = 7'b1000001;

    localparam logic [0:6] SEG_DIGIT [0:9] = '{
        7'b0000001,
        7'b1001111,
        7'b0010010,
        7'b0000110,
        7'b1001100,
        7'b0100100,
        7'b0100000,
        7'b0001111,
        7'b0000000,
        7'b0000100
    };

    typedef enum logic [1:0] {
        DISP_EMPTY,
        DISP_NORMAL,
        DISP_FULL
    } dispState_e;

endpackage

// File: rtl/seg7_digit.sv
// Combinational BCD to active-low seven-segment decoder with blanking.
// Non-decimal codes show blank rather than garbage.
module seg7_digit
    import occupancy_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [0:6] seg
);

    // Pick the digit glyph unless blanked or out of decimal range
    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd <= 4'd9)) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/occupancy_counter.sv
// Saturating parking-lot occupancy counter fed by single-cycle entry/exit
// pulses, with full/empty/reject flags and a registered six-digit display
// showing either the count or a CLEAr / FULL banner.
module occupancy_counter
    import occupancy_pkg::*;
#(
    parameter  int CAPACITY = 16,
    localparam int CW       = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          reject,
    output logic [0:6]    HEX0,
    output logic [0:6]    HEX1,
    output logic [0:6]    HEX2,
    output logic [0:6]    HEX3,
    output logic [0:6]    HEX4,
    output logic [0:6]    HEX5
);

    localparam logic [CW-1:0] CAP = CW'(CAPACITY);

    logic [CW-1:0] countQ, countD;
    logic          fullQ, fullD;
    logic          emptyQ, emptyD;
    logic          rejectQ, rejectD;

    dispState_e    dispState;
    logic [6:0]    countWide;
    logic [3:0]    tensBcd, unitsBcd;
    logic          tensBlank;
    logic [0:6]    tensSeg, unitsSeg;
    logic [0:6]    hex0D, hex1D, hex2D, hex3D, hex4D, hex5D;
    logic [0:6]    hex0Q, hex1Q, hex2Q, hex3Q, hex4Q, hex5Q;

    // Next occupancy: simultaneous entry and exit cancel, otherwise saturate and flag
    always_comb begin
        countD  = countQ;
        rejectD = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (countQ < CAP) countD = countQ + CW'(1);
                else              rejectD = 1'b1;
            end
            2'b01: begin
                if (countQ != '0) countD = countQ - CW'(1);
                else              rejectD = 1'b1;
            end
            default: ;
        endcase
        fullD  = (countD == CAP);
        emptyD = (countD == '0);
    end

    // Count and status flags update together so they never disagree
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            countQ  <= '0;
            fullQ   <= 1'b0;
            emptyQ  <= 1'b1;
            rejectQ <= 1'b0;
        end else begin
            countQ  <= countD;
            fullQ   <= fullD;
            emptyQ  <= emptyD;
            rejectQ <= rejectD;
        end
    end

    // Classify the registered count and split it into decimal digits
    always_comb begin
        if (countQ == '0)       dispState = DISP_EMPTY;
        else if (countQ == CAP) dispState = DISP_FULL;
        else                    dispState = DISP_NORMAL;
        countWide = 7'(countQ);
        tensBcd   = 4'(countWide / 7'd10);
        unitsBcd  = 4'(countWide % 7'd10);
        tensBlank = (dispState == DISP_NORMAL) && (tensBcd == 4'd0);
    end

    seg7_digit u_tens (
        .bcd   (tensBcd),
        .blank (tensBlank),
        .seg   (tensSeg)
    );

    seg7_digit u_units (
        .bcd   (unitsBcd),
        .blank (1'b0),
        .seg   (unitsSeg)
    );

    // Banner selection for the six displays based on the display state
    always_comb begin
        hex5D = SEG_BLANK;
        hex4D = SEG_BLANK;
        hex3D = SEG_BLANK;
        hex2D = SEG_BLANK;
        hex1D = tensSeg;
        hex0D = unitsSeg;
        case (dispState)
            DISP_EMPTY: begin
                hex5D = SEG_C;
                hex4D = SEG_L;
                hex3D = SEG_E;
                hex2D = SEG_A;
                hex1D = SEG_r;
                hex0D = SEG_DIGIT[0];
            end
            DISP_FULL: begin
                hex5D = SEG_F;
                hex4D = SEG_U;
                hex3D = SEG_L;
                hex2D = SEG_L;
            end
            default: ;
        endcase
    end

    // Display register stage; resets straight to the CLEAr0 banner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex5Q <= SEG_C;
            hex4Q <= SEG_L;
            hex3Q <= SEG_E;
            hex2Q <= SEG_A;
            hex1Q <= SEG_r;
            hex0Q <= SEG_DIGIT[0];
        end else begin
            hex5Q <= hex5D;
            hex4Q <= hex4D;
            hex3Q <= hex3D;
            hex2Q <= hex2D;
            hex1Q <= hex1D;
            hex0Q <= hex0D;
        end
    end

    assign count  = countQ;
    assign full   = fullQ;
    assign empty  = emptyQ;
    assign reject = rejectQ;
    assign HEX0   = hex0Q;
    assign HEX1   = hex1Q;
    assign HEX2   = hex2Q;
    assign HEX3   = hex3Q;
    assign HEX4   = hex4Q;
    assign HEX5   = hex5Q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Testbench for occupancy_counter: directed scenarios followed by a biased
// random walk, all compared against an arithmetic occupancy model.
module tb_occupancy_counter;

    localparam int CAP = 16;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk;
    logic          reset;
    logic          incIn;
    logic          decIn;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          reject;
    logic [0:6]    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int            checks = 0;
    int            errors = 0;

    int            modelCount;
    logic          modelReject;
    logic [41:0]   expHex;

    occupancy_counter #(.CAPACITY(CAP)) dut (
        .clk    (clk),
        .reset  (reset),
        .inc    (incIn),
        .dec    (decIn),
        .count  (count),
        .full   (full),
        .empty  (empty),
        .reject (reject),
        .HEX0   (HEX0),
        .HEX1   (HEX1),
        .HEX2   (HEX2),
        .HEX3   (HEX3),
        .HEX4   (HEX4),
        .HEX5   (HEX5)
    );

    // Free-running 100 MHz-style clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] digitGlyph(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // What the six displays should read for a given occupancy
    function automatic logic [41:0] displayOf(input int c);
        logic [6:0] blankG;
        logic [6:0] tensG;
        blankG = 7'b1111111;
        if (c == 0)
            return {7'b0110001, 7'b1110001, 7'b0110000, 7'b0001000, 7'b1111010, digitGlyph(0)};
        if (c == CAP)
            return {7'b0111000, 7'b1000001, 7'b1110001, 7'b1110001, digitGlyph(c / 10), digitGlyph(c % 10)};
        tensG = (c / 10 == 0) ? blankG : digitGlyph(c / 10);
        return {blankG, blankG, blankG, blankG, tensG, digitGlyph(c % 10)};
    endfunction

    task automatic modelReset();
        modelCount  = 0;
        modelReject = 1'b0;
        expHex      = displayOf(0);
    endtask

    task automatic checkOutput(input string tag);
        logic [41:0] hexNow;
        hexNow = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        checks++;
        assert (count === CW'(modelCount)) else begin
            errors++;
            $error("[TB] FAIL %s count: got %0d expected %0d", tag, count, modelCount);
        end
        checks++;
        assert (full === (modelCount == CAP)) else begin
            errors++;
            $error("[TB] FAIL %s full: got %b expected %b", tag, full, (modelCount == CAP));
        end
        checks++;
        assert (empty === (modelCount == 0)) else begin
            errors++;
            $error("[TB] FAIL %s empty: got %b expected %b", tag, empty, (modelCount == 0));
        end
        checks++;
        assert (reject === modelReject) else begin
            errors++;
            $error("[TB] FAIL %s reject: got %b expected %b", tag, reject, modelReject);
        end
        checks++;
        assert (hexNow === expHex) else begin
            errors++;
            $error("[TB] FAIL %s hex: got %h expected %h", tag, hexNow, expHex);
        end
    endtask

    // Drive one cycle of inc/dec, advance the model, and check at the falling edge
    task automatic applyStimulus(input logic i, input logic d, input string tag);
        incIn = i;
        decIn = d;
        @(posedge clk);
        expHex      = displayOf(modelCount);
        modelReject = 1'b0;
        if (i && !d) begin
            if (modelCount < CAP) modelCount++;
            else                  modelReject = 1'b1;
        end else if (d && !i) begin
            if (modelCount > 0) modelCount--;
            else                modelReject = 1'b1;
        end
        @(negedge clk);
        incIn = 1'b0;
        decIn = 1'b0;
        checkOutput(tag);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge
    task automatic asyncReset(input string tag);
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int incP;
        int decP;
        logic ri;
        logic rd;

        reset = 1'b0;
        incIn = 1'b0;
        decIn = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_hold");
        reset = 1'b1;

        $display("[TB] idle after reset");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, "idle");

        $display("[TB] three separate entries");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, "inc3");
            applyStimulus(1'b0, 1'b0, "inc3_gap");
        end
        applyStimulus(1'b0, 1'b0, "inc3_display");

        $display("[TB] async reset at count 5");
        applyStimulus(1'b1, 1'b0, "to5");
        applyStimulus(1'b1, 1'b0, "to5");
        asyncReset("reset_at5");
        applyStimulus(1'b1, 1'b0, "first_after_reset");
        asyncReset("reset_again");

        $display("[TB] fill to capacity and overflow");
        for (int k = 0; k < CAP; k++) applyStimulus(1'b1, 1'b0, "fill");
        applyStimulus(1'b0, 1'b0, "full_display");
        applyStimulus(1'b1, 1'b0, "overflow");
        applyStimulus(1'b0, 1'b0, "overflow_clear");

        $display("[TB] inc and dec together at full");
        applyStimulus(1'b1, 1'b1, "both_full");
        applyStimulus(1'b1, 1'b1, "both_full");
        applyStimulus(1'b0, 1'b0, "both_full_idle");

        $display("[TB] underflow and simultaneous at empty");
        asyncReset("reset_for_empty");
        applyStimulus(1'b0, 1'b1, "underflow");
        applyStimulus(1'b0, 1'b0, "underflow_clear");
        applyStimulus(1'b1, 1'b1, "both_empty");
        applyStimulus(1'b0, 1'b1, "underflow_b2b");
        applyStimulus(1'b0, 1'b1, "underflow_b2b");

        $display("[TB] held inc from 9");
        for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, "to9");
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, "held_inc");
        applyStimulus(1'b0, 1'b0, "held_display");

        $display("[TB] random walk");
        for (int k = 0; k < 600; k++) begin
            if (((k / 60) % 2) == 0) begin
                incP = 70;
                decP = 25;
            end else begin
                incP = 25;
                decP = 70;
            end
            ri = ($urandom_range(0, 99) < incP);
            rd = ($urandom_range(0, 99) < decP);
            applyStimulus(ri, rd, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/occupancy_counter.md
# occupancy_counter

Downstream stage of the parking-lot entry/exit sensor FSM. Consumes the FSM's single-cycle `inc` (car entered) and `dec` (car left) pulses. Maintains a saturating occupancy count bounded by a lot capacity, flags full/empty and rejected events, and drives the six DE1-SoC seven-segment displays with either the count or a "CLEAr"/"FULL" banner.

## Interface
- `CAPACITY`, default 16: maximum occupancy; legal range 1..99.
- `CW`, default `$clog2(CAPACITY+1)`: count width; derived, not overridden.
- `clk  input  1`: system clock (CLOCK_50).
- `reset  input  1`: asynchronous active-low reset.
- `inc  input  1`: entry event; each cycle sampled high counts one entry.
- `dec  input  1`: exit event; each cycle sampled high counts one exit.
- `count  output  CW`: current occupancy, registered.
- `full  output  1`: registered; high when `count == CAPACITY`.
- `empty  output  1`: registered; high when `count == 0`.
- `reject  output  1`: registered one-cycle pulse when an event is discarded by saturation.
- `HEX0..HEX5  output  [0:6] each`: registered, active-low segments; index 0 = segment a … index 6 = segment g.

## Operation
- Per-cycle update priority:
  - `inc & dec`: net zero. Count unchanged, `reject` = 0, including at full or empty.
  - `inc` only: if `count < CAPACITY`, count+1; else count holds and `reject` = 1 next cycle.
  - `dec` only: if `count > 0`, count−1; else count holds and `reject` = 1 next cycle.
  - Neither: hold.
- No edge detection. Upstream guarantees one-cycle pulses; a level held N cycles counts N events, saturating.
- `full` and `empty` are registered alongside `count` and are never both high. CAPACITY ≥ 1 guarantees this.
- Display state is decoded from the registered count:
  - EMPTY (`count == 0`): HEX5..HEX1 = C, L, E, A, r; HEX0 = 0.
  - FULL (`count == CAPACITY`): HEX5..HEX2 = F, U, L, L; HEX1:HEX0 = decimal count.
  - NORMAL: HEX5..HEX2 blank; HEX1 = tens digit, blanked when zero; HEX0 = units digit.
- Decimal split: tens = count/10, units = count%10. Computed combinationally on CW bits; valid because CAPACITY ≤ 99.
- Reset values (async assert, sync release):
  - `count` = 0, `empty` = 1, `full` = 0, `reject` = 0.
  - HEX5..HEX0 = "CLEAr0" patterns. Displays never show blank or garbage out of reset.

## Timing
- `inc`/`dec` sampled at edge N: `count`, `full`, `empty`, `reject` valid after edge N (1-cycle latency).
- HEX outputs valid after edge N+1 (one extra register stage after the decode).
- `reject` is high for exactly one cycle per discarded event. Back-to-back discarded events give back-to-back high cycles.
- Reset mid-operation: all outputs go to reset values immediately, without waiting for a clock edge. Pulses arriving during reset are lost.
- First edge after reset deassertion with `inc` = 1: count becomes 1.

## Structure
- Package `occupancy_pkg` holds:
  - Active-low glyph constants: `SEG_BLANK` = 1111111, `SEG_C`, `SEG_L`, `SEG_E`, `SEG_A`, `SEG_r`, `SEG_F`, `SEG_U`.
  - `SEG_DIGIT[0:9]` array (e.g. 0 = 0000001, 1 = 1001111, 6 = 0100000).
  - Display-state enum `{DISP_EMPTY, DISP_NORMAL, DISP_FULL}`.
- Sub-module `seg7_digit`: 4-bit BCD in, `[0:6]` active-low out, plus a `blank` input. Purely combinational; instantiated for HEX1 and HEX0.
- Banner muxing and all output registers live in `occupancy_counter`.

## Test plan
- Reset then idle 3 cycles -> count 0, empty 1, full 0, HEX5..HEX0 = C, L, E, A, r, 0. Assert reset at count 5 -> same values asynchronously, before the next edge.
- Three separate `inc` pulses -> count 3, empty 0; after one more cycle, HEX0 = 0000110 and HEX1..HEX5 = 1111111.
- 16 `inc` pulses (CAPACITY 16) -> full 1; HEX5..HEX0 = F, U, L, L, 1, 6. A 17th `inc` -> count stays 16, `reject` high for exactly one cycle.
- From count 0, `dec` pulse -> count 0, `reject` one cycle, empty stays 1. Then `inc` + `dec` in the same cycle -> count 0, `reject` 0.
- At count 16, `inc` and `dec` together for 2 cycles -> count 16, `reject` 0, full stays 1.
- `inc` held high 4 cycles from count 9 -> count 13; HEX1 = '1', HEX0 = '3'; `reject` never asserted.
